mem_port_arbiter: RTL

- Sequences all accesses to the single-ported unified instruction/data memory with a fixed multi-cycle latency.
- The two requesters are the IF stage (instruction read) and the Mem stage (data load/store).
- Arbitrates between them, holds the memory port stable for each access, and returns read data with a ready strobe.
- Generates the fetch and data stall signals that drive PC/IF_ID keep and whole-pipeline hold.

---
 rtl/mem_port_arbiter_if.sv | 37 +++
 rtl/mem_port_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundles the IF/Mem requester handshakes and the unified memory port of mem_port_arbiter.
// master = requesters plus memory model side; slave = the arbiter itself.
interface mem_port_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ready;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_ready;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          fetch_stall;
    logic          data_stall;
    logic          busy;

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_ready, dm_rdata, dm_ready, mem_en, mem_we, mem_addr, mem_wdata,
        input  fetch_stall, data_stall, busy
    );

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_ready, dm_rdata, dm_ready, mem_en, mem_we, mem_addr, mem_wdata,
        output fetch_stall, data_stall, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter for the single-ported unified I/D memory: data has priority from idle, and a completing
// access hands the port straight to the other waiting port. MEM_ARB_PERF_EN adds stall counters.
module mem_port_arbiter #(
    parameter int unsigned MEM_LAT = 2,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32
) (
    input  logic        clk,
    input  logic        Reset_n,
`ifdef MEM_ARB_PERF_EN
    output logic [31:0] fetch_wait_cnt,
    output logic [31:0] data_wait_cnt,
`endif
    mem_port_arbiter_if.slave bus_io
);

    typedef enum logic [1:0] {StIdle, StFetch, StData} state_e;

    localparam logic [3:0] CntInit = 4'(MEM_LAT - 1);

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          we_q, we_d;
    logic [DW-1:0] if_hold_q, if_hold_d;
    logic [DW-1:0] dm_hold_q, dm_hold_d;

    logic          done;
    logic          latch_fetch;
    logic          latch_data;
    logic          if_ready;
    logic          dm_ready;

    assign done     = (cnt_q == 4'd0);
    assign if_ready = (state_q == StFetch) && done;
    assign dm_ready = (state_q == StData) && done;

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            if_hold_q <= '0;
            dm_hold_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            if_hold_q <= if_hold_d;
            dm_hold_q <= dm_hold_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        if_hold_d   = if_hold_q;
        dm_hold_d   = dm_hold_q;
        latch_fetch = 1'b0;
        latch_data  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus_io.dm_req) begin
                    latch_data = 1'b1;
                end else if (bus_io.if_req) begin
                    latch_fetch = 1'b1;
                end
            end
            StFetch: begin
                if (done) begin
                    if_hold_d = bus_io.mem_rdata;
                    // Never chain fetch to fetch: only a waiting data access follows directly.
                    if (bus_io.dm_req) begin
                        latch_data = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StData: begin
                if (done) begin
                    if (!we_q) begin
                        dm_hold_d = bus_io.mem_rdata;
                    end
                    if (bus_io.if_req) begin
                        latch_fetch = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
        endcase

        if (latch_data) begin
            state_d = StData;
            cnt_d   = CntInit;
            addr_d  = bus_io.dm_addr;
            we_d    = bus_io.dm_we;
            wdata_d = bus_io.dm_wdata;
        end else if (latch_fetch) begin
            state_d = StFetch;
            cnt_d   = CntInit;
            addr_d  = bus_io.if_addr;
        end
    end

    // Port controls decode from state only, so an asynchronous reset drops them at once.
    assign bus_io.mem_en      = (state_q != StIdle);
    assign bus_io.mem_we      = (state_q == StData) && we_q;
    assign bus_io.mem_addr    = addr_q;
    assign bus_io.mem_wdata   = wdata_q;
    assign bus_io.if_ready    = if_ready;
    assign bus_io.dm_ready    = dm_ready;
    assign bus_io.if_rdata    = if_ready ? bus_io.mem_rdata : if_hold_q;
    assign bus_io.dm_rdata    = (dm_ready && !we_q) ? bus_io.mem_rdata : dm_hold_q;
    assign bus_io.fetch_stall = bus_io.if_req && !if_ready;
    assign bus_io.data_stall  = bus_io.dm_req && !dm_ready;
    assign bus_io.busy        = (state_q != StIdle);

`ifdef MEM_ARB_PERF_EN
    logic [31:0] fetch_wait_q, fetch_wait_d;
    logic [31:0] data_wait_q, data_wait_d;

    always_comb begin
        fetch_wait_d = fetch_wait_q;
        data_wait_d  = data_wait_q;
        if (bus_io.fetch_stall && (fetch_wait_q != 32'hFFFF_FFFF)) begin
            fetch_wait_d = fetch_wait_q + 32'd1;
        end
        if (bus_io.data_stall && (data_wait_q != 32'hFFFF_FFFF)) begin
            data_wait_d = data_wait_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fetch_wait_q <= 32'd0;
            data_wait_q  <= 32'd0;
        end else begin
            fetch_wait_q <= fetch_wait_d;
            data_wait_q  <= data_wait_d;
        end
    end

    assign fetch_wait_cnt = fetch_wait_q;
    assign data_wait_cnt  = data_wait_q;
`endif

endmodule
